// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: turns a beat stream into packed weight-bank words or per-beat bias-bank words.
module weight_load_ctrl #(
  parameter int CHL_PARA        = 8,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int BANK_UNIT_WIDTH = 8,
  localparam int BEAT_W = CHL_PARA * BANK_UNIT_WIDTH,
  localparam int WEIT_W = CHL_PARA * BEAT_W,
  localparam int BIAS_W = BEAT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_type_i,
  input  logic [BANK_ADDR_WIDTH-1:0] cmd_base_addr_i,
  input  logic [BANK_ADDR_WIDTH-1:0] cmd_len_i,
  input  logic                       load_data_valid_i,
  output logic                       load_data_ready_o,
  input  logic [BEAT_W-1:0]          load_data_i,
  output logic                       weight_write_en_o,
  output logic [BANK_ADDR_WIDTH-1:0] weight_write_addr_o,
  output logic [WEIT_W-1:0]          weight_write_data_o,
  output logic                       bias_write_en_o,
  output logic [BANK_ADDR_WIDTH-1:0] bias_write_addr_o,
  output logic [BIAS_W-1:0]          bias_write_data_o,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int CW = CHL_PARA > 1 ? $clog2(CHL_PARA) : 1;
  localparam logic [1:0] IDLE = 2'd0, LOAD_W = 2'd1, LOAD_B = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [BANK_ADDR_WIDTH-1:0] base, len, word_cnt;
  logic [CW-1:0] beat_cnt;
  logic [WEIT_W-1:0] asm_q, asm_next;
  logic beat_ok, last_beat, last_word;
  assign cmd_ready_o       = state == IDLE;
  assign load_data_ready_o = state == LOAD_W || state == LOAD_B;
  assign busy_o            = !cmd_ready_o;
  assign done_o            = state == DONE;
  assign beat_ok   = load_data_valid_i && load_data_ready_o;
  // every bias beat is a whole word; weight words need CHL_PARA beats
  assign last_beat = state == LOAD_B || beat_cnt == CW'(CHL_PARA - 1);
  assign last_word = word_cnt == len;
  always_comb begin
    asm_next = asm_q;
    asm_next[beat_cnt*BEAT_W +: BEAT_W] = load_data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      base                <= '0;
      len                 <= '0;
      word_cnt            <= '0;
      beat_cnt            <= '0;
      asm_q               <= '0;
      weight_write_en_o   <= 1'b0;
      weight_write_addr_o <= '0;
      weight_write_data_o <= '0;
      bias_write_en_o     <= 1'b0;
      bias_write_addr_o   <= '0;
      bias_write_data_o   <= '0;
    end else begin
      weight_write_en_o <= 1'b0;
      bias_write_en_o   <= 1'b0;
      case (state)
        IDLE: if (cmd_valid_i) begin
          base     <= cmd_base_addr_i;
          len      <= cmd_len_i;
          word_cnt <= '0;
          beat_cnt <= '0;
          state    <= cmd_type_i ? LOAD_B : LOAD_W;
        end
        LOAD_W, LOAD_B: if (beat_ok) begin
          beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
          if (state == LOAD_W) asm_q <= asm_next;
          if (last_beat) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) state <= DONE;
          end
          if (state == LOAD_W && last_beat) begin
            weight_write_en_o   <= 1'b1;
            weight_write_addr_o <= base + word_cnt;
            weight_write_data_o <= asm_next;
          end
          if (state == LOAD_B) begin
            bias_write_en_o   <= 1'b1;
            bias_write_addr_o <= base + word_cnt;
            bias_write_data_o <= load_data_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: scoreboard bench; the driver predicts writes from the load rules, a monitor checks them.
module tb_weight_load_ctrl;
  localparam int CP = 8, AW = 12, BW = 64, WW = 512;
  logic clk = 0, rst_n = 0;
  logic cmd_valid_i = 0, cmd_ready_o, cmd_type_i = 0;
  logic [AW-1:0] cmd_base_addr_i = 0, cmd_len_i = 0;
  logic load_data_valid_i = 0, load_data_ready_o;
  logic [BW-1:0] load_data_i = 0;
  logic weight_write_en_o, bias_write_en_o, busy_o, done_o;
  logic [AW-1:0] weight_write_addr_o, bias_write_addr_o;
  logic [WW-1:0] weight_write_data_o;
  logic [BW-1:0] bias_write_data_o;

  weight_load_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_type_i(cmd_type_i),
    .cmd_base_addr_i(cmd_base_addr_i), .cmd_len_i(cmd_len_i),
    .load_data_valid_i(load_data_valid_i), .load_data_ready_o(load_data_ready_o), .load_data_i(load_data_i),
    .weight_write_en_o(weight_write_en_o), .weight_write_addr_o(weight_write_addr_o),
    .weight_write_data_o(weight_write_data_o),
    .bias_write_en_o(bias_write_en_o), .bias_write_addr_o(bias_write_addr_o),
    .bias_write_data_o(bias_write_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          t;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
    logic          dn;
    int            c;
  } exp_t;
  exp_t sb[$];
  logic [BW-1:0] wq[$];
  int total = 0, bad = 0, cyc = 0, last_done = -100, done_cnt = 0, acc_cyc = 0;
  logic mt;
  logic [AW-1:0] mb, ml, mw;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (done_o) begin
        last_done = cyc;
        done_cnt++;
      end
      if (weight_write_en_o || bias_write_en_o) begin
        chk("dual_strobe", weight_write_en_o & bias_write_en_o, 0);
        if (sb.size() == 0) chk("spurious_write", {weight_write_en_o, bias_write_en_o}, 0);
        else begin
          e = sb.pop_front();
          chk("wr_type", bias_write_en_o, e.t);
          chk("wr_addr", e.t ? bias_write_addr_o : weight_write_addr_o, e.a);
          chk("wr_data", e.t ? WW'(bias_write_data_o) : weight_write_data_o, e.d);
          chk("wr_done", done_o, e.dn);
          chk("wr_cycle", cyc, e.c);
        end
      end else if (done_o) chk("done_without_write", done_o, 0);
    end
  end

  // a beat accepted at the coming edge yields its write one cycle later
  task automatic model_beat(input logic [BW-1:0] d);
    exp_t e;
    e.c = cyc + 1;
    e.t = mt;
    e.a = mb + mw;
    e.dn = mw == ml;
    if (mt) begin
      e.d = WW'(d);
      sb.push_back(e);
      mw++;
    end else begin
      wq.push_back(d);
      if (wq.size() == CP) begin
        for (int k = 0; k < CP; k++) e.d[k*BW +: BW] = wq[k];
        sb.push_back(e);
        wq.delete();
        mw++;
      end
    end
  endtask

  task automatic issue(input logic t, input logic [AW-1:0] b, input logic [AW-1:0] l);
    int n = 0;
    @(negedge clk);
    cmd_valid_i = 1; cmd_type_i = t; cmd_base_addr_i = b; cmd_len_i = l; load_data_valid_i = 0;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_timeout", n < 50, 1);
    acc_cyc = cyc;
    mt = t; mb = b; ml = l; mw = 0;
    wq.delete();
  endtask

  task automatic send(input int cnt, input bit pat, input int gap, input int stall_after);
    int i = 0, g = 0, st = 0;
    bit v;
    logic [BW-1:0] d;
    while (i < cnt && g < cnt * 20 + 100) begin
      @(negedge clk);
      cmd_valid_i = 0;
      g++;
      v = $urandom_range(99) >= gap;
      if (stall_after >= 0 && i == stall_after + 1 && st < 5) begin
        v = 0;
        st++;
      end
      d = pat ? BW'(i) : {$urandom, $urandom};
      load_data_valid_i = v;
      load_data_i = d;
      if (v && load_data_ready_o) begin
        model_beat(d);
        i++;
      end
    end
    chk("beat_timeout", i, cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cmd_valid_i = 0;
      load_data_valid_i = 0;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_data_ready", load_data_ready_o, 0);
    chk("rst_w_en", weight_write_en_o, 0);
    chk("rst_w_addr", weight_write_addr_o, 0);
    chk("rst_w_data", weight_write_data_o, 0);
    chk("rst_b_en", bias_write_en_o, 0);
    chk("rst_b_addr", bias_write_addr_o, 0);
    chk("rst_b_data", bias_write_data_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    logic t;
    logic [AW-1:0] l;
    #3 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    // two packed weight words with beat i = i
    issue(0, 12'h010, 1);
    send(16, 1, 0, -1);
    // bias command waiting through the DONE cycle, then wrapping past 0xFFF
    issue(1, 12'hFFE, 3);
    chk("b2b_accept_cycle", acc_cyc, last_done + 1);
    send(4, 0, 0, -1);
    idle(3);
    // stall after beat 3
    issue(0, 12'h020, 0);
    send(8, 1, 0, 3);
    idle(3);
    // beats offered in IDLE are refused
    repeat (10) begin
      @(negedge clk);
      load_data_valid_i = 1;
      load_data_i = {$urandom, $urandom};
      chk("idle_data_ready", load_data_ready_o, 0);
    end
    issue(1, 12'h100, 1);
    send(2, 0, 0, -1);
    idle(3);
    // reset in the middle of a weight word
    issue(0, 12'h200, 0);
    send(6, 1, 0, -1);
    @(negedge clk);
    load_data_valid_i = 0;
    rst_n = 0;
    wq.delete();
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1;
    d0 = done_cnt;
    issue(1, 12'h300, 0);
    send(1, 0, 0, -1);
    idle(3);
    chk("post_reset_done_pulses", done_cnt - d0, 1);
    repeat (12) begin
      t = 1'($urandom);
      l = AW'($urandom_range(0, 3));
      issue(t, AW'($urandom), l);
      send((int'(l) + 1) * (t ? 1 : CP), 0, 30, -1);
      idle($urandom_range(0, 3));
    end
    // maximum length wraps the whole address space
    issue(1, AW'($urandom), 12'hFFF);
    send(4096, 0, 0, -1);
    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
- REQ-001 SHALL have parameter CHL_PARA, default 8: channel parallelism; units per weight/bias bank.
- REQ-002 SHALL have parameter BANK_ADDR_WIDTH, default 12: bank address width.
- REQ-003 SHALL have parameter BANK_UNIT_WIDTH, default 8: quantized unit width.
- REQ-004 SHALL define derived widths:
  - BEAT_W = CHL_PARA*BANK_UNIT_WIDTH (64).
  - WEIT_W = CHL_PARA*BEAT_W (512).
  - BIAS_W = BEAT_W.
- REQ-005 SHALL have these ports, clock and reset first; one clock; reset is asynchronous and active-low:
  - clk  in  1  clock
  - rst_n  in  1  asynchronous active-low reset
  - cmd_valid_i  in  1  load command valid
  - cmd_ready_o  out  1  command accepted when valid&ready
  - cmd_type_i  in  1  0=weight, 1=bias
  - cmd_base_addr_i  in  BANK_ADDR_WIDTH  first write address
  - cmd_len_i  in  BANK_ADDR_WIDTH  number of words minus 1
  - load_data_valid_i  in  1  stream beat valid
  - load_data_ready_o  out  1  stream beat accepted when valid&ready
  - load_data_i  in  BEAT_W  stream beat
  - weight_write_en_o  out  1  weight group write strobe
  - weight_write_addr_o  out  BANK_ADDR_WIDTH  weight write address
  - weight_write_data_o  out  WEIT_W  packed weight word
  - bias_write_en_o  out  1  bias group write strobe
  - bias_write_addr_o  out  BANK_ADDR_WIDTH  bias write address
  - bias_write_data_o  out  BIAS_W  bias word
  - busy_o  out  1  command in progress
  - done_o  out  1  one-cycle completion pulse

Function
- REQ-006 SHALL implement FSM states IDLE, LOAD_W, LOAD_B, DONE.
- REQ-007 cmd_ready_o SHALL be 1 exactly in IDLE.
- REQ-008 On command accept, SHALL latch base address and length, clear beat and word counters, and enter LOAD_W (type 0) or LOAD_B (type 1) next cycle.
- REQ-009 load_data_ready_o SHALL be 1 exactly in LOAD_W and LOAD_B; beats presented in IDLE/DONE SHALL be neither accepted nor stored.
- REQ-010 In LOAD_W, accepted beat k (k=0..CHL_PARA-1) SHALL be stored into bits [(k+1)*BEAT_W-1 : k*BEAT_W] of the assembly register.
- REQ-011 Weight word completion:
  - Condition: beat CHL_PARA-1 accepted at cycle t.
  - Cycle t+1: weight_write_en_o=1, weight_write_data_o = full assembled word, weight_write_addr_o = base + word index.
- REQ-012 In LOAD_B, each accepted beat SHALL produce bias_write_en_o=1 in the next cycle, with bias_write_data_o = beat and bias_write_addr_o = base + word index.
- REQ-013 Write strobes SHALL be high for exactly one cycle per word; otherwise low.
- REQ-014 Address arithmetic SHALL be modulo 2^BANK_ADDR_WIDTH; wrap from max address to 0 SHALL be silent.
- REQ-015 Stalls (valid low) SHALL hold all counters and partial data; there is no backpressure from the write side.
- REQ-016 When the final beat of word index cmd_len is accepted, SHALL enter DONE.
- REQ-017 In DONE, SHALL drive the final write strobe and done_o=1 simultaneously, then return to IDLE the following cycle.
- REQ-018 busy_o SHALL be 1 in LOAD_W, LOAD_B and DONE, and 0 in IDLE.
- REQ-019 cmd_len_i = 0 SHALL load exactly one word; cmd_len_i = all-ones SHALL load 2^BANK_ADDR_WIDTH words.
- REQ-020 Output data registers SHALL hold their last value when strobes are low.

Reset
- REQ-021 On rst_n low, asynchronously:
  - FSM SHALL go to IDLE.
  - Counters, assembly register and all outputs SHALL clear to 0, except cmd_ready_o, which SHALL be 1.
- REQ-022 Reset mid-command SHALL discard any partial word without issuing a write; after release, the block SHALL accept a new command normally.

Verification
- REQ-023 Weight load: type 0, base 0x010, len 1, 16 beats with beat i = i → 2 weight writes:
  - addr 0x010, data beats 0..7 (beat 0 in LSBs).
  - addr 0x011, beats 8..15.
  - done_o coincides with second write.
- REQ-024 Bias wrap: type 1, base 0xFFE, len 3, beats A,B,C,D → bias writes at 0xFFE, 0xFFF, 0x000, 0x001 with data A,B,C,D, each one cycle after its beat.
- REQ-025 Stall: weight load with valid deasserted for 5 cycles after beat 3 → single write, data identical to unstalled case, no spurious strobes.
- REQ-026 IDLE traffic: load_data_valid_i=1 in IDLE for 10 cycles → ready=0, no writes; a subsequent command consumes only later beats.
- REQ-027 Reset mid-op: rst_n low after beat 5 of a weight word → no write, outputs 0, cmd_ready_o=1; a new bias command, len 0, then completes with one write and one done_o pulse.
- REQ-028 Back-to-back: new command presented in the DONE cycle → not accepted until the IDLE cycle; accepted the cycle after DONE.
